multdiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the pipelined core's execute stage. It replaces the fixed 32-bit multdiv with a configurable-width datapath and four operations (signed mult, signed div, signed rem, unsigned div). It adds a valid/ready handshake with result backpressure, a destination-tag pass-through, and a pipeline-flush abort. It computes one bit per cycle, with an early exit on division by zero.

---
 rtl/multdiv_iter.sv | 167 ++++++++++++++++
 tb/tb_multdiv_iter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle,
// valid/ready handshake on both sides, tag pass-through and flush abort.
module multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_REM = 2'b10, OP_DIVU = 2'b11} op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier bits / dividend bits -> quotient
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d, dz_q, dz_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic               signed_op, a_neg, b_neg, div_zero, qneg, mul_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, remd;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod_mag, prod;

    always_comb begin
        signed_op = (op != OP_DIVU);
        a_neg     = signed_op & operand_a[WIDTH-1];
        b_neg     = signed_op & operand_b[WIDTH-1];
        a_mag     = a_neg ? -operand_a : operand_a;
        b_mag     = b_neg ? -operand_b : operand_b;
        div_zero  = (op != OP_MUL) && (operand_b == '0);

        mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q & {WIDTH{lo_q[0]}}};
        div_sh    = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_sh - {1'b0, opnd_q};

        qneg      = neg_a_q ^ neg_b_q;
        prod_mag  = {hi_q, lo_q};
        prod      = qneg ? -prod_mag : prod_mag;
        // product fits in WIDTH signed bits iff its top WIDTH+1 bits are all equal
        mul_ovf   = (|prod[2*WIDTH-1:WIDTH-1]) & ~(&prod[2*WIDTH-1:WIDTH-1]);
        quo       = qneg ? -lo_q : lo_q;
        remd      = neg_a_q ? -hi_q : hi_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                op_d    = op_t'(op);
                tag_d   = in_tag;
                neg_a_d = a_neg;
                neg_b_d = b_neg;
                dz_d    = div_zero;
                cnt_d   = '0;
                hi_d    = '0;
                opnd_d  = (op == OP_MUL) ? a_mag : b_mag;
                lo_d    = (op == OP_MUL) ? b_mag : a_mag;
                // divide by zero skips the iterations; FIX emits the 0/exception result
                state_d = div_zero ? S_FIX : S_RUN;
            end
            S_RUN: begin
                if (op_q == OP_MUL) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else if (!div_diff[WIDTH]) begin
                    hi_d = div_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (dz_q) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    case (op_q)
                        OP_MUL:  begin result_d = prod[WIDTH-1:0]; exc_d = mul_ovf; end
                        // only MIN / -1 yields a positive quotient with the top bit set
                        OP_DIV:  begin result_d = quo;  exc_d = ~qneg & lo_q[WIDTH-1]; end
                        OP_REM:  begin result_d = remd; exc_d = 1'b0; end
                        OP_DIVU: begin result_d = lo_q; exc_d = 1'b0; end
                    endcase
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = out_valid ? result_q : '0;
    assign exception = out_valid & exc_q;
    assign out_tag   = out_valid ? tag_q : '0;
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter at WIDTH=32/TAG_W=5 and WIDTH=8/TAG_W=3.
module tb_multdiv_iter;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic        iv, ir, fl, ov, ordy, exc, bsy;
    logic [1:0]  op;
    logic [31:0] a, b, res;
    logic [4:0]  tag, otag;

    logic        iv8, ir8, ov8, ordy8, exc8, bsy8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  tag8, otag8;

    int total = 0, bad = 0;

    multdiv_iter #(.WIDTH(32), .TAG_W(5)) dut (
        .clock(clock), .reset(reset), .in_valid(iv), .in_ready(ir), .op(op),
        .operand_a(a), .operand_b(b), .in_tag(tag), .flush(fl), .out_valid(ov),
        .out_ready(ordy), .result(res), .exception(exc), .out_tag(otag), .busy(bsy));

    multdiv_iter #(.WIDTH(8), .TAG_W(3)) dut8 (
        .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8), .op(op8),
        .operand_a(a8), .operand_b(b8), .in_tag(tag8), .flush(1'b0), .out_valid(ov8),
        .out_ready(ordy8), .result(res8), .exception(exc8), .out_tag(otag8), .busy(bsy8));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    localparam logic [1:0] MUL = 2'b00, DIV = 2'b01, REM = 2'b10, DIVU = 2'b11;

    vec_t tbl[19];
    vec_t t8[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    // called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
        iv = 1'b1; op = o; a = x; b = y; tag = t;
        cyc();
        iv = 1'b0;
    endtask

    // number of edges after the accept edge until out_valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!ov && lat < 100) begin
            cyc();
            lat++;
        end
    endtask

    task automatic drain();
        ordy = 1'b1;
        cyc();
        ordy = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        chk({nm, " in_ready"}, 64'(ir), 64'd1);
        issue(v.op, v.a, v.b, v.tag);
        wait_valid(lat);
        chk({nm, " latency"}, 64'(lat), 64'(v.lat));
        chk({nm, " result"}, 64'(res), 64'(v.res));
        chk({nm, " exception"}, 64'(exc), 64'(v.exc));
        chk({nm, " tag"}, 64'(otag), 64'(v.tag));
        chk({nm, " in_ready in DONE"}, 64'(ir), 64'd0);
        drain();
        chk({nm, " idle after take"}, 64'({ov, ir, bsy}), 64'b010);
    endtask

    task automatic run8(input vec_t v, input string nm);
        int lat;
        iv8 = 1'b1; op8 = v.op; a8 = v.a[7:0]; b8 = v.b[7:0]; tag8 = v.tag[2:0];
        cyc();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin
            cyc();
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(v.lat));
        chk({nm, " result"}, 64'(res8), 64'(v.res[7:0]));
        chk({nm, " exception"}, 64'(exc8), 64'(v.exc));
        chk({nm, " tag"}, 64'(otag8), 64'(v.tag[2:0]));
        ordy8 = 1'b1;
        cyc();
        ordy8 = 1'b0;
        chk({nm, " idle after take"}, 64'({ov8, ir8}), 64'b01);
    endtask

    initial begin
        int lat;
        logic saw;
        tbl[0]  = '{MUL,  32'h7,        32'hFFFFFFFA, 5'd9,  32'hFFFFFFD6, 1'b0, 33};
        tbl[1]  = '{MUL,  32'h00010000, 32'h00010000, 5'd1,  32'h00000000, 1'b1, 33};
        tbl[2]  = '{MUL,  32'h80000000, 32'h1,        5'd2,  32'h80000000, 1'b0, 33};
        tbl[3]  = '{MUL,  32'h80000000, 32'hFFFFFFFF, 5'd3,  32'h80000000, 1'b1, 33};
        tbl[4]  = '{MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000001, 1'b0, 33};
        tbl[5]  = '{DIV,  32'hFFFFFFF9, 32'h2,        5'd5,  32'hFFFFFFFD, 1'b0, 33};
        tbl[6]  = '{REM,  32'hFFFFFFF9, 32'h2,        5'd6,  32'hFFFFFFFF, 1'b0, 33};
        tbl[7]  = '{DIVU, 32'hFFFFFFFE, 32'h2,        5'd7,  32'h7FFFFFFF, 1'b0, 33};
        tbl[8]  = '{DIV,  32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h80000000, 1'b1, 33};
        tbl[9]  = '{REM,  32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000, 1'b0, 33};
        tbl[10] = '{DIV,  32'h5,        32'h0,        5'd11, 32'h00000000, 1'b1, 1};
        tbl[11] = '{REM,  32'h5,        32'h0,        5'd12, 32'h00000000, 1'b1, 1};
        tbl[12] = '{DIVU, 32'h5,        32'h0,        5'd13, 32'h00000000, 1'b1, 1};
        tbl[13] = '{DIV,  32'h64,       32'hFFFFFFF9, 5'd14, 32'hFFFFFFF2, 1'b0, 33};
        tbl[14] = '{REM,  32'h64,       32'hFFFFFFF9, 5'd15, 32'h00000002, 1'b0, 33};
        tbl[15] = '{DIVU, 32'h80000000, 32'h3,        5'd16, 32'h2AAAAAAA, 1'b0, 33};
        tbl[16] = '{REM,  32'hFFFFFF9C, 32'h7,        5'd17, 32'hFFFFFFFE, 1'b0, 33};
        tbl[17] = '{MUL,  32'h00007FFF, 32'h00010001, 5'd18, 32'h7FFF7FFF, 1'b0, 33};
        tbl[18] = '{MUL,  32'h00010000, 32'hFFFF8000, 5'd19, 32'h80000000, 1'b0, 33};

        t8[0] = '{MUL, 32'h07, 32'hFA, 5'd5, 32'hD6, 1'b0, 9};
        t8[1] = '{DIV, 32'hF9, 32'h02, 5'd1, 32'hFD, 1'b0, 9};
        t8[2] = '{MUL, 32'h10, 32'h10, 5'd2, 32'h00, 1'b1, 9};
        t8[3] = '{REM, 32'hF9, 32'h02, 5'd3, 32'hFF, 1'b0, 9};
        t8[4] = '{DIV, 32'h80, 32'hFF, 5'd4, 32'h80, 1'b1, 9};
        t8[5] = '{DIV, 32'h05, 32'h00, 5'd6, 32'h00, 1'b1, 1};

        iv = 0; fl = 0; ordy = 0; op = 0; a = 0; b = 0; tag = 0;
        iv8 = 0; ordy8 = 0; op8 = 0; a8 = 0; b8 = 0; tag8 = 0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        chk("reset in_ready/out_valid/busy", 64'({ir, ov, bsy}), 64'b100);
        chk("reset result", 64'(res), 64'd0);
        chk("reset exception/tag", 64'({exc, otag}), 64'd0);
        chk("reset w8 in_ready/out_valid/busy", 64'({ir8, ov8, bsy8}), 64'b100);

        for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("v%0d", i));
        for (int i = 0; i < 6; i++) run8(t8[i], $sformatf("w8v%0d", i));

        // backpressure, plus requests presented while RUN and DONE
        issue(MUL, 32'd3, 32'd5, 5'd7);
        iv = 1'b1; op = DIV; a = 32'd100; b = 32'd3; tag = 5'd2;
        wait_valid(lat);
        chk("bp latency", 64'(lat), 64'd33);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("bp hold %0d valid/ready", k), 64'({ov, ir}), 64'b10);
            chk($sformatf("bp hold %0d result/tag", k), 64'({res, otag}), 64'({32'd15, 5'd7}));
        end
        drain();
        chk("bp no accept on DONE->IDLE edge", 64'({ir, bsy, ov}), 64'b100);
        cyc();
        iv = 1'b0;
        chk("bp accepted next cycle", 64'(bsy), 64'd1);
        wait_valid(lat);
        chk("bp second latency", 64'(lat), 64'd33);
        chk("bp second result/tag", 64'({res, otag}), 64'({32'd33, 5'd2}));
        drain();

        // flush ten edges into a multiply
        issue(MUL, 32'd7, 32'd9, 5'd4);
        repeat (9) cyc();
        fl = 1'b1;
        cyc();
        fl = 1'b0;
        chk("flush -> idle", 64'({ir, bsy, ov}), 64'b100);
        saw = 1'b0;
        repeat (40) begin
            cyc();
            if (ov) saw = 1'b1;
        end
        chk("flush no out_valid", 64'(saw), 64'd0);
        run_vec(tbl[0], "post-flush");

        // flush discards a pending DONE result
        issue(MUL, 32'd2, 32'd3, 5'd1);
        wait_valid(lat);
        fl = 1'b1;
        cyc();
        fl = 1'b0;
        chk("flush in DONE", 64'({ov, ir, exc, otag, res}), 64'({3'b010, 5'd0, 32'd0}));

        // reset while in FIX
        issue(MUL, 32'h7, 32'hFFFFFFFA, 5'd9);
        repeat (32) cyc();
        chk("in FIX busy/valid", 64'({bsy, ov}), 64'b10);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("reset in FIX state", 64'({ir, ov, bsy}), 64'b100);
        chk("reset in FIX outputs", 64'({exc, otag, res}), 64'd0);
        cyc();
        chk("reset in FIX stays idle", 64'({ov, bsy}), 64'b00);

        // flush and in_valid together in IDLE
        iv = 1'b1; fl = 1'b1; op = MUL; a = 32'd3; b = 32'd3; tag = 5'd3;
        cyc();
        iv = 1'b0; fl = 1'b0;
        chk("flush blocks accept", 64'({ir, bsy}), 64'b10);
        run_vec(tbl[5], "post-block");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
